// File: rtl/placar_sequenciador_if.sv
// Point-event and shared-converter signals between the scoreboard controller and its environment.
interface placar_sequenciador_if;
  logic       pts_valid;
  logic       pts_team;
  logic [1:0] pts_val;
  logic       pts_sub;
  logic       clr;
  logic [6:0] conv_bin;
  logic [7:0] conv_bcd;
  logic       conv_passou99;

  modport master (
    output pts_valid, pts_team, pts_val, pts_sub, clr,
    input  conv_bin,
    output conv_bcd, conv_passou99
  );

  modport slave (
    input  pts_valid, pts_team, pts_val, pts_sub, clr,
    output conv_bin,
    input  conv_bcd, conv_passou99
  );
endinterface

// File: rtl/placar_sequenciador.sv
// Basketball score controller: applies point events, time-shares the external BCD converter for both teams.
// Optional subtraction (correction) events are enabled by defining PLACAR_CORRECAO_EN.
module placar_sequenciador #(
  parameter int MAX_PLACAR = 99
) (
  input  logic                    clk,
  input  logic                    rst_n,
  placar_sequenciador_if.slave    bus,
  output logic [6:0]              score_a,
  output logic [6:0]              score_b,
  output logic [7:0]              bcd_a,
  output logic [7:0]              bcd_b,
  output logic                    over_a,
  output logic                    over_b,
  output logic                    conv_err,
  output logic                    busy,
  output logic                    disp_valid,
  output logic                    drop
);

  localparam logic [7:0] MAX8 = 8'(MAX_PLACAR);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    CONV_A,
    CONV_B
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       cur_team;
  logic [1:0] cur_val;
  logic       cur_sub;

  logic       pend_full;
  logic       pend_team;
  logic [1:0] pend_val;
  logic       pend_sub;

  logic       load_cur;
  logic       take_pend;
  logic       want_queue;
  logic       store_pend;
  logic       drop_evt;

  logic [6:0] cur_score;
  logic [7:0] sum;
  logic [6:0] upd_score;
  logic       upd_over;

`ifdef PLACAR_CORRECAO_EN
  logic signed [7:0] diff;
`else
  logic       unused_sub;
  assign unused_sub = cur_sub;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.pts_valid || pend_full) state_next = UPDATE;
      UPDATE:  state_next = CONV_A;
      CONV_A:  state_next = CONV_B;
      CONV_B:  state_next = pend_full ? UPDATE : IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.clr) state_next = CONV_A;
  end

  // A queued event always runs before a newly arriving one; the newcomer may refill the slot it frees.
  always_comb begin
    load_cur   = 1'b0;
    take_pend  = 1'b0;
    want_queue = 1'b0;
    store_pend = 1'b0;
    drop_evt   = 1'b0;
    if (!bus.clr) begin
      load_cur   = (state == IDLE && (bus.pts_valid || pend_full)) ||
                   (state == CONV_B && pend_full);
      take_pend  = load_cur && pend_full;
      want_queue = bus.pts_valid && (state != IDLE || pend_full);
      store_pend = want_queue && (!pend_full || take_pend);
      drop_evt   = want_queue && !store_pend;
    end
  end

  always_comb begin
    cur_score = cur_team ? score_b : score_a;
    sum       = {1'b0, cur_score} + {6'b0, cur_val};
    upd_over  = (sum > MAX8);
    upd_score = upd_over ? MAX8[6:0] : sum[6:0];
`ifdef PLACAR_CORRECAO_EN
    diff = $signed({1'b0, cur_score}) - $signed({6'b0, cur_val});
    if (cur_sub) begin
      upd_over  = 1'b0;
      upd_score = diff[7] ? 7'd0 : diff[6:0];
    end
`endif
  end

  assign busy         = (state != IDLE);
  assign bus.conv_bin = (state == CONV_B) ? score_b : score_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      score_a    <= 7'd0;
      score_b    <= 7'd0;
      bcd_a      <= 8'h00;
      bcd_b      <= 8'h00;
      over_a     <= 1'b0;
      over_b     <= 1'b0;
      conv_err   <= 1'b0;
      disp_valid <= 1'b0;
      drop       <= 1'b0;
      cur_team   <= 1'b0;
      cur_val    <= 2'd0;
      cur_sub    <= 1'b0;
      pend_full  <= 1'b0;
      pend_team  <= 1'b0;
      pend_val   <= 2'd0;
      pend_sub   <= 1'b0;
    end else begin
      state      <= state_next;
      disp_valid <= 1'b0;
      drop       <= drop_evt;
      if (bus.clr) begin
        score_a   <= 7'd0;
        score_b   <= 7'd0;
        over_a    <= 1'b0;
        over_b    <= 1'b0;
        conv_err  <= 1'b0;
        pend_full <= 1'b0;
      end else begin
        if (load_cur) begin
          cur_team <= pend_full ? pend_team : bus.pts_team;
          cur_val  <= pend_full ? pend_val  : bus.pts_val;
          cur_sub  <= pend_full ? pend_sub  : bus.pts_sub;
        end
        if (store_pend) begin
          pend_full <= 1'b1;
          pend_team <= bus.pts_team;
          pend_val  <= bus.pts_val;
          pend_sub  <= bus.pts_sub;
        end else if (take_pend) begin
          pend_full <= 1'b0;
        end

        case (state)
          UPDATE: begin
            if (cur_team) begin
              score_b <= upd_score;
              over_b  <= over_b | upd_over;
            end else begin
              score_a <= upd_score;
              over_a  <= over_a | upd_over;
            end
          end
          CONV_A: begin
            bcd_a    <= bus.conv_bcd;
            conv_err <= conv_err | bus.conv_passou99;
          end
          CONV_B: begin
            bcd_b      <= bus.conv_bcd;
            conv_err   <= conv_err | bus.conv_passou99;
            disp_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_placar_sequenciador.sv
// Directed bench for placar_sequenciador with a behavioural binary-to-BCD converter stub.
module tb_placar_sequenciador;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] score_a, score_b;
  logic [7:0] bcd_a, bcd_b;
  logic       over_a, over_b, conv_err, busy, disp_valid, drop;

  logic       ovr_en;
  logic [7:0] ovr_bcd;

  int tests_run    = 0;
  int tests_failed = 0;
  int dv_count;

  always #5 clk = ~clk;

  placar_sequenciador_if intf ();

  placar_sequenciador #(.MAX_PLACAR(99)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (intf.slave),
    .score_a    (score_a),
    .score_b    (score_b),
    .bcd_a      (bcd_a),
    .bcd_b      (bcd_b),
    .over_a     (over_a),
    .over_b     (over_b),
    .conv_err   (conv_err),
    .busy       (busy),
    .disp_valid (disp_valid),
    .drop       (drop)
  );

  // Converter stub; the override lets the bench inject an error result in a chosen cycle.
  always_comb begin
    intf.conv_bcd      = {4'(intf.conv_bin / 10), 4'(intf.conv_bin % 10)};
    intf.conv_passou99 = (intf.conv_bin > 7'd99);
    if (ovr_en) begin
      intf.conv_bcd      = ovr_bcd;
      intf.conv_passou99 = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic team, input logic [1:0] val, input logic sub);
    intf.pts_valid = 1'b1;
    intf.pts_team  = team;
    intf.pts_val   = val;
    intf.pts_sub   = sub;
    step();
    intf.pts_valid = 1'b0;
    intf.pts_val   = 2'd0;
    intf.pts_sub   = 1'b0;
  endtask

  task automatic runEvent(input logic team, input logic [1:0] val, input logic sub);
    applyStimulus(team, val, sub);
    repeat (3) step();
  endtask

  initial begin
    rst_n          = 1'b0;
    intf.pts_valid = 1'b0;
    intf.pts_team  = 1'b0;
    intf.pts_val   = 2'd0;
    intf.pts_sub   = 1'b0;
    intf.clr       = 1'b0;
    ovr_en         = 1'b0;
    ovr_bcd        = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_disp_valid", disp_valid, 0);
    end
    checkOutput("rst_score_a", score_a, 0);
    checkOutput("rst_score_b", score_b, 0);
    checkOutput("rst_bcd_a", bcd_a, 8'h00);
    checkOutput("rst_bcd_b", bcd_b, 8'h00);
    checkOutput("rst_flags", {over_a, over_b, conv_err, drop}, 4'b0000);

    // Single event latency: A+3
    applyStimulus(1'b0, 2'd3, 1'b0);
    checkOutput("a3_busy_n1", busy, 1);
    checkOutput("a3_score_n1", score_a, 0);
    step();
    checkOutput("a3_score_n2", score_a, 3);
    checkOutput("a3_busy_n2", busy, 1);
    step();
    checkOutput("a3_bcd_a_n3", bcd_a, 8'h03);
    checkOutput("a3_dv_n3", disp_valid, 0);
    step();
    checkOutput("a3_bcd_b_n4", bcd_b, 8'h00);
    checkOutput("a3_dv_n4", disp_valid, 1);
    checkOutput("a3_busy_n4", busy, 0);
    step();
    checkOutput("a3_dv_n5", disp_valid, 0);

    // Team B to 98, then saturate
    for (int i = 0; i < 32; i++) runEvent(1'b1, 2'd3, 1'b0);
    runEvent(1'b1, 2'd2, 1'b0);
    checkOutput("b98_score", score_b, 98);
    checkOutput("b98_bcd", bcd_b, 8'h98);
    checkOutput("b98_over", over_b, 0);
    runEvent(1'b1, 2'd3, 1'b0);
    checkOutput("b99_score", score_b, 99);
    checkOutput("b99_bcd", bcd_b, 8'h99);
    checkOutput("b99_over", over_b, 1);
    runEvent(1'b1, 2'd0, 1'b0);
    checkOutput("b_noop_dv", disp_valid, 1);
    checkOutput("b_noop_over_sticky", over_b, 1);
    checkOutput("b_noop_score", score_b, 99);
    checkOutput("a_untouched", score_a, 3);
    checkOutput("a_over_clear", over_a, 0);

    // clr with a coincident event that must vanish silently
    intf.clr       = 1'b1;
    intf.pts_valid = 1'b1;
    intf.pts_team  = 1'b0;
    intf.pts_val   = 2'd1;
    step();
    intf.clr       = 1'b0;
    intf.pts_valid = 1'b0;
    checkOutput("clr_score_a", score_a, 0);
    checkOutput("clr_score_b", score_b, 0);
    checkOutput("clr_over_b", over_b, 0);
    checkOutput("clr_busy", busy, 1);
    checkOutput("clr_no_drop", drop, 0);
    step();
    checkOutput("clr_bcd_a", bcd_a, 8'h00);
    checkOutput("clr_dv_early", disp_valid, 0);
    step();
    checkOutput("clr_bcd_b", bcd_b, 8'h00);
    checkOutput("clr_dv", disp_valid, 1);
    checkOutput("clr_idle", busy, 0);
    checkOutput("clr_event_discarded", score_a, 0);

    // Back-to-back: A+1 runs, B+2 queued, A+2 dropped
    applyStimulus(1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0);
    checkOutput("b2b_drop", drop, 1);
    dv_count = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) checkOutput("b2b_drop_pulse", drop, 0);
      if (disp_valid) dv_count++;
    end
    checkOutput("b2b_dv_count", dv_count, 2);
    checkOutput("b2b_score_a", score_a, 1);
    checkOutput("b2b_score_b", score_b, 2);
    checkOutput("b2b_bcd_a", bcd_a, 8'h01);
    checkOutput("b2b_bcd_b", bcd_b, 8'h02);
    checkOutput("b2b_conv_err", conv_err, 0);

    // Converter error injected during CONV_B
    applyStimulus(1'b0, 2'd0, 1'b0);
    step();
    step();
    ovr_en  = 1'b1;
    ovr_bcd = 8'h55;
    step();
    ovr_en = 1'b0;
    checkOutput("err_bcd_b", bcd_b, 8'h55);
    checkOutput("err_flag", conv_err, 1);
    checkOutput("err_bcd_a", bcd_a, 8'h01);
    runEvent(1'b0, 2'd0, 1'b0);
    checkOutput("err_sticky", conv_err, 1);
    checkOutput("err_bcd_b_restored", bcd_b, 8'h02);
    intf.clr = 1'b1;
    step();
    intf.clr = 1'b0;
    checkOutput("err_cleared", conv_err, 0);
    step();
    step();
    checkOutput("clr2_bcd_a", bcd_a, 8'h00);

    // Correction event
    runEvent(1'b0, 2'd2, 1'b0);
    checkOutput("corr_pre", score_a, 2);
    runEvent(1'b0, 2'd3, 1'b1);
`ifdef PLACAR_CORRECAO_EN
    checkOutput("corr_score_a", score_a, 0);
    checkOutput("corr_bcd_a", bcd_a, 8'h00);
`else
    checkOutput("corr_score_a", score_a, 5);
    checkOutput("corr_bcd_a", bcd_a, 8'h05);
`endif
    checkOutput("corr_over_a", over_a, 0);

    // Reset in the middle of a sequence
    applyStimulus(1'b1, 2'd3, 1'b0);
    step();
    checkOutput("mid_score_b", score_b, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_score_b", score_b, 0);
    checkOutput("mid_rst_score_a", score_a, 0);
    checkOutput("mid_rst_bcd_a", bcd_a, 8'h00);
    step();
    checkOutput("mid_rst_dv", disp_valid, 0);
    checkOutput("mid_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
